// File: rtl/sum_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// sum_seq_ctrl_if
// Request/result bus of the bit-serial adder sequencer.
//   start  : request a new operation (honoured only while the sequencer idles)
//   x, y   : operands, sampled on accept
//   sub    : subtract select, sampled on accept (only with SUM_SEQ_SUB_EN)
//   busy   : operation in progress
//   done   : one-cycle result-valid pulse
//   o      : sum result, held until the next accept
//   carry  : final carry-out (no-borrow flag when subtracting)
// Modports: master = requester side, slave = sequencer side.
// Optional feature macro: SUM_SEQ_SUB_EN
// ---------------------------------------------------------------------------
interface sum_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
`ifdef SUM_SEQ_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] o;
    logic             carry;

`ifdef SUM_SEQ_SUB_EN
    modport master (output start, x, y, sub, input busy, done, o, carry);
    modport slave  (input start, x, y, sub, output busy, done, o, carry);
`else
    modport master (output start, x, y, input busy, done, o, carry);
    modport slave  (input start, x, y, output busy, done, o, carry);
`endif
endinterface

// File: rtl/sum_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sum_seq_ctrl
// Bit-serial WIDTH-bit adder that time-shares one external 1-bit full-adder
// cell, LSB first, one bit per clock.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : request/result bus (sum_seq_ctrl_if.slave)
//   fa_a     : to cell, current bit of operand A
//   fa_b     : to cell, current bit of operand B
//   fa_cin   : to cell, running carry
//   fa_s     : from cell, sum bit (combinational)
//   fa_cout  : from cell, carry bit
// Optional feature macro: SUM_SEQ_SUB_EN (adds bus.sub, computes x + ~y + 1)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; o/carry hold the last result
// RUN   | one operand bit per clock through the external cell
// DONE  | one-cycle done pulse, result valid
// ---------------------------------------------------------------------------
module sum_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sum_seq_ctrl_if.slave bus,
    output logic          fa_a,
    output logic          fa_b,
    output logic          fa_cin,
    input  logic          fa_s,
    input  logic          fa_cout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xr_q, xr_d;
    logic [WIDTH-1:0] yr_q, yr_d;
    logic             cr_q, cr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             carry_q, carry_d;

    logic accept;
    logic last_bit;
    logic busy;
    logic done;

    assign accept   = (state_q == ST_IDLE) && bus.start;
    assign last_bit = (idx_q == IDX_LAST);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (last_bit)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state outputs; the cell inputs are forced low outside RUN
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                busy   = 1'b1;
                fa_a   = xr_q[idx_q];
                fa_b   = yr_q[idx_q];
                fa_cin = cr_q;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.o     = o_q;
    assign bus.carry = carry_q;

    // datapath
    always_comb begin
        xr_d    = xr_q;
        yr_d    = yr_q;
        cr_d    = cr_q;
        idx_d   = idx_q;
        o_d     = o_q;
        carry_d = carry_q;
        if (accept) begin
            xr_d  = bus.x;
`ifdef SUM_SEQ_SUB_EN
            // subtraction as x + ~y + 1: invert B, seed the carry with 1
            yr_d  = bus.sub ? ~bus.y : bus.y;
            cr_d  = bus.sub;
`else
            yr_d  = bus.y;
            cr_d  = 1'b0;
`endif
            idx_d = '0;
        end else if (state_q == ST_RUN) begin
            o_d[idx_q] = fa_s;
            cr_d       = fa_cout;
            if (last_bit) begin
                carry_d = fa_cout;
            end else begin
                // idx stops at the last bit; it is cleared on the next accept
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr_q    <= '0;
            yr_q    <= '0;
            cr_q    <= 1'b0;
            idx_q   <= '0;
            o_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            cr_q    <= cr_d;
            idx_q   <= idx_d;
            o_q     <= o_d;
            carry_q <= carry_d;
        end
    end

endmodule
